// File: rtl/in_arb_if.sv
// rtl/in_arb_if.sv - byte stream bundle between requesters A/B, the arbiter and the IN channel
interface in_arb_if;
  logic [7:0] a_data_i;
  logic       a_valid_i;
  logic       a_ready_o;
  logic [7:0] b_data_i;
  logic       b_valid_i;
  logic       b_ready_o;
  logic [7:0] in_data_o;
  logic       in_valid_o;
  logic       in_ready_i;
  logic [1:0] grant_o;

  modport slave (
    input  a_data_i, a_valid_i, b_data_i, b_valid_i, in_ready_i,
    output a_ready_o, b_ready_o, in_data_o, in_valid_o, grant_o
  );

  modport master (
    output a_data_i, a_valid_i, b_data_i, b_valid_i, in_ready_i,
    input  a_ready_o, b_ready_o, in_data_o, in_valid_o, grant_o
  );
endinterface

// File: rtl/in_arb.sv
// rtl/in_arb.sv - round-robin burst arbiter of two byte requesters onto one IN channel
module in_arb #(
  parameter int BURST_LEN = 8
) (
  input  logic    clk_i,
  input  logic    rst_i,
  in_arb_if.slave bus
);

  typedef enum logic [1:0] {IDLE, GNT_A, GNT_B} state_t;

  localparam logic [7:0] LAST_CNT = 8'(BURST_LEN - 1);

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       last_b, last_b_nxt;
  logic       xfer;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= IDLE;
      cnt    <= 8'h00;
      last_b <= 1'b1;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      last_b <= last_b_nxt;
    end
  end

  // Data path is a pure mux on the owner; only the grant decision is registered.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    last_b_nxt    = last_b;
    xfer          = 1'b0;
    bus.grant_o   = 2'b00;
    bus.in_data_o = 8'h00;
    bus.in_valid_o = 1'b0;
    bus.a_ready_o = 1'b0;
    bus.b_ready_o = 1'b0;

    case (state)
      IDLE: begin
        cnt_nxt = 8'h00;
        if (bus.a_valid_i && (!bus.b_valid_i || last_b))
          state_nxt = GNT_A;
        else if (bus.b_valid_i)
          state_nxt = GNT_B;
      end

      GNT_A: begin
        bus.grant_o    = 2'b01;
        bus.in_data_o  = bus.a_data_i;
        bus.in_valid_o = bus.a_valid_i;
        bus.a_ready_o  = bus.in_ready_i;
        xfer           = bus.a_valid_i & bus.in_ready_i;
        if (!bus.a_valid_i) begin
          state_nxt  = IDLE;
          last_b_nxt = 1'b0;
        end else if (xfer) begin
          cnt_nxt = cnt + 8'd1;
          if (cnt == LAST_CNT) begin
            state_nxt  = IDLE;
            last_b_nxt = 1'b0;
          end
        end
      end

      GNT_B: begin
        bus.grant_o    = 2'b10;
        bus.in_data_o  = bus.b_data_i;
        bus.in_valid_o = bus.b_valid_i;
        bus.b_ready_o  = bus.in_ready_i;
        xfer           = bus.b_valid_i & bus.in_ready_i;
        if (!bus.b_valid_i) begin
          state_nxt  = IDLE;
          last_b_nxt = 1'b1;
        end else if (xfer) begin
          cnt_nxt = cnt + 8'd1;
          if (cnt == LAST_CNT) begin
            state_nxt  = IDLE;
            last_b_nxt = 1'b1;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/in_arb.md
IN_ARB -- requirements
Module: in_arb

Interface
REQ-001 Parameter BURST_LEN, default 8, is the maximum number of bytes per grant (legal 1..255; matches IN bulk max packet size).
REQ-002 clk_i  input  1  single clock; all state on rising edge.
REQ-003 rst_i  input  1  reset, asynchronous, active-high.
REQ-004 a_data_i  input  8  requester A byte.
REQ-005 a_valid_i  input  1  requester A byte valid.
REQ-006 a_ready_o  output  1  requester A byte accepted when a_valid_i & a_ready_o.
REQ-007 b_data_i  input  8  requester B byte.
REQ-008 b_valid_i  input  1  requester B byte valid.
REQ-009 b_ready_o  output  1  requester B byte accepted when b_valid_i & b_ready_o.
REQ-010 in_data_o  output  8  byte to USB CDC IN channel.
REQ-011 in_valid_o  output  1  byte valid to USB CDC IN channel.
REQ-012 in_ready_i  input  1  USB CDC IN channel ready.
REQ-013 grant_o  output  2  one-hot owner: 01 = A, 10 = B, 00 = idle.

Function
REQ-014 FSM states IDLE, GNT_A, GNT_B; grant_o SHALL be 01 in GNT_A, 10 in GNT_B, 00 in IDLE.
REQ-015 In IDLE: in_valid_o, a_ready_o, b_ready_o SHALL be 0; in_data_o SHALL be 8'h00.
REQ-016 IDLE, only A valid -> GNT_A next cycle; only B valid -> GNT_B next cycle; neither -> stay IDLE.
REQ-017 IDLE, both valid -> grant the requester not served last (last pointer); after reset the pointer SHALL favour A.
REQ-018 In GNT_X: in_data_o = X_data_i, in_valid_o = X_valid_i, X_ready_o = in_ready_i, other ready = 0 (combinational pass-through, zero-latency data path).
REQ-019 Transfer SHALL be X_valid_i & in_ready_i in GNT_X; burst counter (width 8) SHALL increment by 1 per transfer and clear on entry to a GNT state.
REQ-020 GNT_X -> IDLE when a transfer occurs with counter == BURST_LEN-1 (burst limit reached).
REQ-021 GNT_X -> IDLE when X_valid_i = 0 in that cycle (requester drained); no transfer occurs that cycle.
REQ-022 On every GNT_X -> IDLE transition the last pointer SHALL be set to X.
REQ-023 in_ready_i low in GNT_X with X_valid_i high SHALL hold state, counter and data unchanged (stall, no timeout).
REQ-024 A requester SHALL never see ready high in IDLE or while the other owns the grant; no byte is accepted twice or dropped.
REQ-025 Exactly one IDLE (arbitration) cycle SHALL separate consecutive grants.
REQ-026 BURST_LEN = 1: every transfer SHALL end the grant; with both valid, grants SHALL alternate A, B, A, ...
REQ-027 Changes on the non-owner's inputs SHALL not affect outputs or state while a grant is held.

Reset
REQ-028 rst_i high SHALL immediately (asynchronously) force IDLE, counter 0, last pointer to B (so A is favoured), and all outputs to 0, including mid-burst.
REQ-029 After rst_i deasserts, the first grant decision SHALL occur on the first rising clk_i edge with rst_i low.

Verification
REQ-030 A streams 20 bytes 0x00..0x13, B idle, in_ready_i = 1, BURST_LEN = 8 -> bursts of 8, 8, 4 bytes each separated by one IDLE cycle, in-order data on in_data_o.
REQ-031 A and B both continuously valid, BURST_LEN = 8 -> grant_o sequence 01 (8 transfers), 00, 10 (8 transfers), 00, 01 ...; A first after reset.
REQ-032 GNT_A, in_ready_i toggled 1,0,0,1,... with a_valid_i = 1 -> a_ready_o mirrors in_ready_i, counter advances only on ready cycles, 8 bytes total before IDLE.
REQ-033 GNT_A after 3 bytes, a_valid_i drops while b_valid_i = 1 -> IDLE next cycle, then GNT_B; A's 4th byte is not accepted.
REQ-034 rst_i asserted mid-burst (GNT_B, counter = 5) between clock edges -> grant_o = 00, in_valid_o = 0, b_ready_o = 0 without a clock edge; after release with both valid, A granted first.
REQ-035 BURST_LEN = 1, both valid, in_ready_i = 1 -> one byte per grant, grant_o alternates 01, 00, 10, 00, 01 ...
